// File: rtl/shiftadd_mul_param.sv
// Parametrised sequential shift-add multiplier, one multiplier bit per clock, signed/unsigned at run time.
// Optional early exit when the remaining multiplier bits are all zero: define SHIFTADD_MUL_EARLY_EXIT_EN.
module shiftadd_mul_param #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   i_B,
  input  logic [N-1:0]   i_Q,
  input  logic           i_signed,
  output logic           busy,
  output logic           stop,
  output logic [2*N-1:0] o_A
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [2*N-1:0] b_q, b_d;
  logic [N-1:0]   q_q, q_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           busy_q, busy_d;
  logic           stop_q, stop_d;
  logic [2*N-1:0] a_q, a_d;

  logic [N-1:0]   b_mag, q_mag;
  logic [2*N-1:0] acc_sum;
  logic           last;

  // Negating the most negative value wraps to itself, which read unsigned is 2^(N-1).
  assign b_mag   = (i_signed && i_B[N-1]) ? -i_B : i_B;
  assign q_mag   = (i_signed && i_Q[N-1]) ? -i_Q : i_Q;
  assign acc_sum = acc_q + (q_q[0] ? b_q : '0);

`ifdef SHIFTADD_MUL_EARLY_EXIT_EN
  assign last = (cnt_q == CW'(N - 1)) || (q_q[N-1:1] == '0);
`else
  assign last = (cnt_q == CW'(N - 1));
`endif

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    stop_d  = stop_q;
    a_d     = a_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          b_d     = {{N{1'b0}}, b_mag};
          q_d     = q_mag;
          neg_d   = i_signed & (i_B[N-1] ^ i_Q[N-1]);
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        acc_d = acc_sum;
        q_d   = q_q >> 1;
        b_d   = b_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          stop_d  = 1'b1;
          a_d     = neg_q ? -acc_sum : acc_sum;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stop_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        stop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
      a_q     <= a_d;
    end
  end

  assign busy = busy_q;
  assign stop = stop_q;
  assign o_A  = a_q;

endmodule

// File: tb/tb_shiftadd_mul_param.sv
// Self-checking bench for shiftadd_mul_param: N=8 instance with a result scoreboard plus an N=16 instance.
module tb_shiftadd_mul_param;

  logic        clk = 1'b0;
  logic        reset, start, i_signed;
  logic [7:0]  i_B, i_Q;
  logic        busy, stop;
  logic [15:0] o_A;

  logic        start16;
  logic [15:0] b16, q16;
  logic        busy16, stop16;
  logic [31:0] a16;

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  shiftadd_mul_param #(.N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .i_B(i_B), .i_Q(i_Q),
    .i_signed(i_signed), .busy(busy), .stop(stop), .o_A(o_A)
  );

  shiftadd_mul_param #(.N(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .i_B(b16), .i_Q(q16),
    .i_signed(1'b0), .busy(busy16), .stop(stop16), .o_A(a16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] model8(input logic [7:0] b, input logic [7:0] q, input logic s);
    longint p;
    if (s) p = longint'($signed(b)) * longint'($signed(q));
    else   p = longint'(b) * longint'(q);
    return p[15:0];
  endfunction

  function automatic int exp_lat8(input logic [7:0] q, input logic s);
`ifdef SHIFTADD_MUL_EARLY_EXIT_EN
    logic [7:0] mag;
    int lat;
    mag = (s && q[7]) ? -q : q;
    lat = 1;
    for (int i = 1; i < 8; i++) if (mag[i]) lat = i + 1;
    return lat;
`else
    return 8;
`endif
  endfunction

  // Called #1 after the accept edge; counts edges until stop and busy samples before it.
  task automatic wait_stop(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (stop !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) check("stop_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [7:0] b, input logic [7:0] q, input logic s);
    int lat, bcnt;
    logic [15:0] exp;
    exp = model8(b, q, s);
    @(negedge clk);
    i_B = b; i_Q = q; i_signed = s; start = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    wait_stop(lat, bcnt);
    check({tag, "_lat"}, lat, exp_lat8(q, s));
    check({tag, "_busy_cycles"}, bcnt, exp_lat8(q, s));
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_A"}, 32'(o_A), 32'(sb_q.pop_front()));
    @(posedge clk); #1;
    check({tag, "_stop_1cyc"}, 32'(stop), 32'd0);
    check({tag, "_hold"}, 32'(o_A), 32'(exp));
  endtask

  initial begin
    int lat, bcnt, seen;
    reset = 1'b1; start = 1'b0; i_signed = 1'b0; i_B = '0; i_Q = '0;
    start16 = 1'b0; b16 = '0; q16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_A", 32'(o_A), 32'd0);
    @(negedge clk); reset = 1'b0;

    do_op("u17x46", 8'd17, 8'd46, 1'b0);
    do_op("s_m3x5", 8'hFD, 8'h05, 1'b1);
    do_op("s_80x80", 8'h80, 8'h80, 1'b1);
    do_op("u_FFxFF", 8'hFF, 8'hFF, 1'b0);
    do_op("s_m10xm10", 8'hF6, 8'hF6, 1'b1);
    do_op("s_7xm1", 8'h07, 8'hFF, 1'b1);
    do_op("u200x1", 8'd200, 8'd1, 1'b0);
    do_op("u200x0", 8'd200, 8'd0, 1'b0);

    // start held high with new operands through RUN and DONE; re-trigger only in IDLE
    @(negedge clk);
    i_B = 8'd17; i_Q = 8'd46; i_signed = 1'b0; start = 1'b1;
    sb_q.push_back(model8(8'd17, 8'd46, 1'b0));
    @(posedge clk); #1;
    i_B = 8'd3; i_Q = 8'd3;
    wait_stop(lat, bcnt);
    check("ign_lat", lat, exp_lat8(8'd46, 1'b0));
    check("ign_A", 32'(o_A), 32'(sb_q.pop_front()));
    sb_q.push_back(model8(8'd3, 8'd3, 1'b0));
    @(posedge clk); #1;
    check("ign_stop_low", 32'(stop), 32'd0);
    check("ign_hold", 32'(o_A), 32'(model8(8'd17, 8'd46, 1'b0)));
    @(posedge clk); #1;
    start = 1'b0;
    check("retrig_busy", 32'(busy), 32'd1);
    wait_stop(lat, bcnt);
    check("retrig_A", 32'(o_A), 32'(sb_q.pop_front()));
    @(posedge clk); #1;

    // reset during the 4th RUN cycle aborts without a stop pulse
    @(negedge clk);
    i_B = 8'd17; i_Q = 8'd46; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_stop", 32'(stop), 32'd0);
    check("abort_A", 32'(o_A), 32'd0);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (stop === 1'b1 || busy === 1'b1) seen++;
    end
    check("abort_quiet", seen, 0);
    do_op("u10x10", 8'd10, 8'd10, 1'b0);

    // N=16 instance
    @(negedge clk);
    b16 = 16'hFFFF; q16 = 16'hFFFF; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (stop16 !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("n16_lat", lat, 16);
    check("n16_A", a16, 32'(longint'(16'hFFFF) * longint'(16'hFFFF)));
    @(posedge clk); #1;
    check("n16_stop_1cyc", 32'(stop16), 32'd0);

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shiftadd_mul_param.md
Name: shiftadd_mul_param

Overview:
Parametrised sequential shift-add multiplier, the successor to the fixed 8-bit shift-add multiplier. It multiplies N-bit i_B (multiplicand) by i_Q (multiplier) and processes one multiplier bit per clock. It adds a busy flag, a run-time signed/unsigned mode and an optional early-exit. It sits as a shared arithmetic unit driven by a control FSM through a start/stop handshake.

Parameters:
N, 8, operand width in bits (N >= 2); product width is 2N.
CW, $clog2(N)+1, width of the internal bit counter (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
i_B  input  N  multiplicand, captured when start is accepted
i_Q  input  N  multiplier, captured when start is accepted
i_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
busy  output  1  high while the operation is in progress (RUN state)
stop  output  1  one-cycle completion pulse; o_A is valid from this cycle onward
o_A  output  2N  product; holds the last result until the next completion

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, busy=0, stop=0, o_A=0, internal registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: capture operands; go to RUN; busy=1.
  - If i_signed=1, capture the magnitudes |i_B| and |i_Q| as N-bit unsigned values. The most negative value maps to 2^(N-1).
  - neg = i_signed & (B[N-1] ^ Q[N-1]).
  - Clear the accumulator and counter.
- RUN, at each edge:
  - If the multiplier LSB is 1, add the shifted multiplicand to the 2N-bit accumulator.
  - Shift the multiplier right by 1 and the multiplicand left by 1 (2N-bit register). Increment the counter.
  - No overflow is possible; the accumulator is 2N bits wide.
- RUN exit: after the N-th bit, at edge E0+N:
  - o_A = neg ? -acc (2N-bit two's complement) : acc.
  - Go to DONE; stop=1; busy=0.
- DONE: stop=1 for exactly one cycle. Next edge: go to IDLE, stop=0.
- Latency: start accepted at E0, stop high in the cycle after edge E0+N. Earliest next accept is edge E0+N+2.
- start in RUN or DONE is ignored. A held-high start re-triggers only once the FSM is back in IDLE.
- Operand inputs are ignored outside the accept edge; changing them mid-operation has no effect.
- o_A changes only on entry to DONE (or on reset).
- Reset asserted in any state: next edge goes to IDLE, busy=0, stop=0, o_A=0. The operation in progress is discarded with no stop pulse.
- Signed range check: -2^(N-1) * -2^(N-1) = 2^(2N-2), which fits as a positive 2N-bit signed value.

Optional Feature:
Macro SHIFTADD_MUL_EARLY_EXIT_EN.
- Defined: RUN exits to DONE at the first edge where the post-shift multiplier register is zero, or after N bits, whichever comes first.
  - Zero multiplier: DONE at edge E0+1.
  - Variable latency of 1..N RUN cycles.
  - Result is identical to the non-early-exit result.
- Not defined: always exactly N RUN cycles. Fixed latency as stated above.

Test Plan:
1. N=8, unsigned, i_B=17, i_Q=46, start pulsed -> busy high 8 cycles; stop one cycle; o_A=16'h030E (782); o_A holds after stop falls.
2. N=8, i_signed=1, i_B=8'hFD (-3), i_Q=8'h05 -> o_A=16'hFFF1 (-15). Repeat with i_B=i_Q=8'h80 -> o_A=16'h4000. Repeat unsigned with i_B=i_Q=8'hFF -> o_A=16'hFE01.
3. Start 17*46. Raise start with new operands (3,3) during RUN and DONE -> ignored; o_A=782. Next start in IDLE gives o_A=9.
4. Assert reset for one cycle at the 4th RUN cycle -> busy=0, o_A=0, no stop pulse. A fresh start of 10*10 -> o_A=100.
5. i_Q=1, i_B=200:
   - Macro defined: stop after 1 RUN cycle.
   - Macro undefined: stop after 8 RUN cycles.
   - Both give o_A=200. i_Q=0 gives o_A=0.
6. N=16 instance, unsigned 16'hFFFF*16'hFFFF -> o_A=32'hFFFE0001 after 16 RUN cycles (macro undefined).
